// File: rtl/alarm_buzzer_driver.sv
// alarm_buzzer_driver
//   Drives the piezo beep pin from the clock controller's alarm request level.
//   While the alarm rings it plays TONE bursts: a square wave of TONE_HZ lasting
//   BEEP_ON_MS. Silent GAP intervals of BEEP_OFF_MS separate the bursts.
//   Ringing stops in three cases:
//     - the alarm request drops, which returns the block to idle;
//     - the alarm-off key is pressed, which mutes the buzzer;
//     - TIMEOUT_S seconds pass, which also mutes the buzzer.
//   A muted alarm stays silent until alarm_on falls and rises again.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   alarm_on         alarm request level
//   alarm_off_pulse  one-cycle debounced alarm-off key pulse
//   beep             buzzer drive (registered)
//   ringing          high while the tone/gap sequence is running (registered)
//
// Timing
//   The outputs are registered from the current state, so they lag the state
//   register by one edge. If a rise is sampled at edge N, the FSM enters TONE at
//   edge N and beep/ringing go high after edge N+1. Exits behave the same way.
module alarm_buzzer_driver #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TONE_HZ     = 2_000,
  parameter int unsigned BEEP_ON_MS  = 200,
  parameter int unsigned BEEP_OFF_MS = 200,
  parameter int unsigned TIMEOUT_S   = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic alarm_on,
  input  logic alarm_off_pulse,
  output logic beep,
  output logic ringing
);

  localparam logic [31:0] HalfCyc = 32'(CLK_FREQ_HZ / (2 * TONE_HZ));
  localparam logic [31:0] OnCyc   = 32'(CLK_FREQ_HZ / 1000 * BEEP_ON_MS);
  localparam logic [31:0] OffCyc  = 32'(CLK_FREQ_HZ / 1000 * BEEP_OFF_MS);
  localparam logic [31:0] ToCyc   = 32'(CLK_FREQ_HZ * TIMEOUT_S);

  typedef enum logic [1:0] {
    StIdle,
    StTone,
    StGap,
    StMuted
  } state_e;

  state_e      state_q, state_d;
  logic        alarm_on_dly_q;
  logic [31:0] phase_cnt_q, phase_cnt_d;  // cycles spent in the current TONE/GAP phase
  logic [31:0] tone_cnt_q, tone_cnt_d;    // position within the current half period
  logic [31:0] to_cnt_q, to_cnt_d;        // total ringing cycles, saturates at ToCyc
  logic        beep_q, beep_d;
  logic        ringing_q, ringing_d;

  logic        rise;
  logic [31:0] to_inc;
  logic        timeout;

  assign rise    = alarm_on & ~alarm_on_dly_q;
  assign to_inc  = to_cnt_q + 32'd1;
  // The cycle in which the count reaches ToCyc is the last ringing cycle.
  assign timeout = (to_inc >= ToCyc);

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    tone_cnt_d  = tone_cnt_q;
    to_cnt_d    = to_cnt_q;
    beep_d      = 1'b0;
    ringing_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        phase_cnt_d = '0;
        tone_cnt_d  = '0;
        to_cnt_d    = '0;
        if (rise) begin
          // A key press in the same cycle as the rise skips straight to mute.
          state_d = alarm_off_pulse ? StMuted : StTone;
        end
      end

      StTone: begin
        ringing_d   = 1'b1;
        phase_cnt_d = phase_cnt_q + 32'd1;
        to_cnt_d    = timeout ? ToCyc : to_inc;
        tone_cnt_d  = (tone_cnt_q == HalfCyc - 32'd1) ? '0 : tone_cnt_q + 32'd1;

        // Entry cycle starts the burst high. After that, toggle once per
        // completed half period.
        if (phase_cnt_q == '0) begin
          beep_d = 1'b1;
        end else if (tone_cnt_q == '0) begin
          beep_d = ~beep_q;
        end else begin
          beep_d = beep_q;
        end

        if (!alarm_on) begin
          state_d = StIdle;
        end else if (alarm_off_pulse || timeout) begin
          state_d = StMuted;
        end else if (phase_cnt_q == OnCyc - 32'd1) begin
          state_d     = StGap;
          phase_cnt_d = '0;
          tone_cnt_d  = '0;
        end
      end

      StGap: begin
        ringing_d   = 1'b1;
        phase_cnt_d = phase_cnt_q + 32'd1;
        to_cnt_d    = timeout ? ToCyc : to_inc;

        if (!alarm_on) begin
          state_d = StIdle;
        end else if (alarm_off_pulse || timeout) begin
          state_d = StMuted;
        end else if (phase_cnt_q == OffCyc - 32'd1) begin
          state_d     = StTone;
          phase_cnt_d = '0;
          tone_cnt_d  = '0;
        end
      end

      StMuted: begin
        // Holding alarm_on high keeps the buzzer muted. Only a fresh rise,
        // seen from idle, can start ringing again.
        if (!alarm_on) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      alarm_on_dly_q <= 1'b0;
      phase_cnt_q    <= '0;
      tone_cnt_q     <= '0;
      to_cnt_q       <= '0;
      beep_q         <= 1'b0;
      ringing_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      alarm_on_dly_q <= alarm_on;
      phase_cnt_q    <= phase_cnt_d;
      tone_cnt_q     <= tone_cnt_d;
      to_cnt_q       <= to_cnt_d;
      beep_q         <= beep_d;
      ringing_q      <= ringing_d;
    end
  end

  assign beep    = beep_q;
  assign ringing = ringing_q;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Directed bench for alarm_buzzer_driver using scaled-down timing.
//   HALF = 5, ON_CYC = 20, OFF_CYC = 10, TO_CYC = 10_000.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, after the registers have settled.
module tb_alarm_buzzer_driver;

  localparam int Half   = 5;
  localparam int OnCyc  = 20;
  localparam int OffCyc = 10;
  localparam int ToCyc  = 10_000;
  localparam int Period = OnCyc + OffCyc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic alarm_on = 1'b0;
  logic alarm_off_pulse = 1'b0;
  logic beep;
  logic ringing;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alarm_buzzer_driver #(
    .CLK_FREQ_HZ(10_000),
    .TONE_HZ    (1_000),
    .BEEP_ON_MS (2),
    .BEEP_OFF_MS(1),
    .TIMEOUT_S  (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alarm_on       (alarm_on),
    .alarm_off_pulse(alarm_off_pulse),
    .beep           (beep),
    .ringing        (ringing)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beep value i cycles after ringing becomes visible (i starts at 1).
  // Each period has 20 tone cycles followed by 10 silent cycles. The tone
  // cycles are high, low, high, low in runs of 5.
  function automatic logic exp_beep(input int i);
    int p;
    p = (i - 1) % Period;
    return (p < OnCyc) && (((p / Half) % 2) == 0);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_beep"}, beep, 1'b0);
    check({tag, "_ringing"}, ringing, 1'b0);
  endtask

  task automatic check_ring(input string tag, input int i);
    check({tag, "_beep"}, beep, exp_beep(i));
    check({tag, "_ringing"}, ringing, 1'b1);
  endtask

  initial begin
    // 1. Reset, then idle with alarm_on low.
    repeat (2) tick();
    check_quiet("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check_quiet("idle");
    end

    // 2. Rise sampled at edge N. Ringing is visible from N+1.
    //    Run two full periods plus a few cycles of a third.
    alarm_on = 1'b1;
    tick();
    check_quiet("rise_edge");
    for (int i = 1; i <= 63; i++) begin
      tick();
      check_ring("pattern", i);
    end

    // 5a. Drop alarm_on mid-TONE.
    alarm_on = 1'b0;
    tick();
    tick();
    check_quiet("drop_mid_tone");
    repeat (5) tick();
    check_quiet("idle_after_drop");

    // 3. Key press 37 cycles into ringing.
    alarm_on = 1'b1;
    tick();
    check_quiet("rise_edge2");
    for (int i = 1; i <= 37; i++) begin
      tick();
      check_ring("pre_key", i);
    end
    alarm_off_pulse = 1'b1;
    tick();
    alarm_off_pulse = 1'b0;
    tick();
    check_quiet("key_mute");
    for (int i = 0; i < 500; i++) begin
      tick();
      check_quiet("held_after_mute");
    end
    alarm_on = 1'b0;
    tick();
    tick();
    check_quiet("released");
    alarm_on = 1'b1;
    tick();
    check_quiet("rearm_rise");
    tick();
    check_ring("rearm", 1);

    // 5b. Key press in the same cycle as the rise.
    alarm_on = 1'b0;
    repeat (3) tick();
    check_quiet("idle_before_same");
    alarm_on = 1'b1;
    alarm_off_pulse = 1'b1;
    tick();
    alarm_off_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_quiet("rise_with_key");
    end
    alarm_on = 1'b0;
    repeat (3) tick();
    check_quiet("idle_before_timeout");

    // 4. Auto-mute after exactly ToCyc ringing cycles.
    alarm_on = 1'b1;
    tick();
    for (int i = 1; i <= ToCyc; i++) begin
      tick();
      check_ring("long_ring", i);
    end
    tick();
    check_quiet("timeout_mute");
    for (int i = 0; i < 50; i++) begin
      tick();
      check_quiet("after_timeout");
    end

    // 6. Asynchronous reset while beep is high.
    alarm_on = 1'b0;
    repeat (2) tick();
    alarm_on = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_ring("pre_reset", i);
    end
    #2 rst = 1'b0;
    #1;
    check_quiet("async_reset");
    tick();
    check_quiet("held_reset");
    rst = 1'b1;
    tick();
    check_quiet("post_reset_edge1");
    tick();
    check_ring("post_reset_edge2", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
